// File: rtl/clock_pkg.sv
// Shared constants, time payload and set-FSM states for the clock datapath.
package clock_pkg;

  localparam int unsigned SECONDS_PER_MINUTE = 60;
  localparam int unsigned MINUTES_PER_HOUR   = 60;
  localparam int unsigned HOURS_PER_HALFDAY  = 12;
  localparam int unsigned HAND_POSITIONS     = 60;

  localparam int unsigned HOUR_W = 4;
  localparam int unsigned MSH_W  = 6;

  // Time of day as carried on the set interface and held in the counters.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MSH_W-1:0]  minute;
    logic [MSH_W-1:0]  second;
  } hms_t;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } set_state_e;

endpackage

// File: rtl/edge_synchronizer.sv
// Synchronizes an asynchronous level and emits a one-cycle rising-edge pulse.
module edge_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Sync chain plus one history flop; all clear to 0 so a high input at release yields one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/time_keeper.sv
// 12-hour time of day driven by the one-second timebase, with a set port and analog hand decode.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MODULUS = HOURS_PER_HALFDAY,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              cmosClock,
  input  logic              resetN,
  input  logic              secondClock,
  input  logic              setValid,
  input  logic [HOUR_W-1:0] setHour,
  input  logic [MSH_W-1:0]  setMinute,
  input  logic [MSH_W-1:0]  setSecond,
  output logic              setReady,
  output logic              setError,
  output logic [HOUR_W-1:0] hours,
  output logic [MSH_W-1:0]  minutes,
  output logic [MSH_W-1:0]  seconds,
  output logic              secondTick,
  output logic [MSH_W-1:0]  hourHand,
  output logic [MSH_W-1:0]  minuteHand,
  output logic [MSH_W-1:0]  secondHand
);

  set_state_e       state_q, state_d;
  hms_t             time_q, time_d, set_req_c;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             stick_q, stick_d;
  logic [MSH_W-1:0] hr_hand_q, hr_hand_d;
  logic [MSH_W-1:0] mn_hand_q, sc_hand_q;
  logic             tick_c, set_ok_c, load_c;
  logic [2:0]       min_fifth_c;

  edge_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sec_sync (
    .clk_i   (cmosClock),
    .rst_ni  (resetN),
    .async_i (secondClock),
    .rise_c  (tick_c)
  );

  assign set_req_c = {setHour, setMinute, setSecond};
  assign set_ok_c  = (32'(setHour) < HOUR_MODULUS) &&
                     (32'(setMinute) < MINUTES_PER_HOUR) &&
                     (32'(setSecond) < SECONDS_PER_MINUTE);

  // Set FSM and counter next state; an accepted set overrides a coincident tick.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    err_d   = 1'b0;
    stick_d = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setValid) begin
          if (set_ok_c) begin
            load_c  = 1'b1;
            state_d = APPLY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      time_d = set_req_c;
    end else if (tick_c) begin
      stick_d = 1'b1;
      if (32'(time_q.second) == SECONDS_PER_MINUTE - 1) begin
        time_d.second = '0;
        if (32'(time_q.minute) == MINUTES_PER_HOUR - 1) begin
          time_d.minute = '0;
          if (32'(time_q.hour) == HOUR_MODULUS - 1) begin
            time_d.hour = '0;
          end else begin
            time_d.hour = time_q.hour + 4'd1;
          end
        end else begin
          time_d.minute = time_q.minute + 6'd1;
        end
      end else begin
        time_d.second = time_q.second + 6'd1;
      end
    end
    ready_d = (state_d == IDLE);
  end

  // Hour hand: five positions per hour plus minute/12 from a threshold chain.
  always_comb begin
    if (time_q.minute >= 6'd48) begin
      min_fifth_c = 3'd4;
    end else if (time_q.minute >= 6'd36) begin
      min_fifth_c = 3'd3;
    end else if (time_q.minute >= 6'd24) begin
      min_fifth_c = 3'd2;
    end else if (time_q.minute >= 6'd12) begin
      min_fifth_c = 3'd1;
    end else begin
      min_fifth_c = 3'd0;
    end
    hr_hand_d = 6'(time_q.hour) * 6'd5 + 6'(min_fifth_c);
  end

  // State, counts, status pulses and hand registers.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      stick_q   <= 1'b0;
      time_q    <= '0;
      hr_hand_q <= '0;
      mn_hand_q <= '0;
      sc_hand_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      stick_q   <= stick_d;
      time_q    <= time_d;
      hr_hand_q <= hr_hand_d;
      mn_hand_q <= time_q.minute;
      sc_hand_q <= time_q.second;
    end
  end

  assign setReady   = ready_q;
  assign setError   = err_q;
  assign secondTick = stick_q;
  assign hours      = time_q.hour;
  assign minutes    = time_q.minute;
  assign seconds    = time_q.second;
  assign hourHand   = hr_hand_q;
  assign minuteHand = mn_hand_q;
  assign secondHand = sc_hand_q;

endmodule
